// File: rtl/register_manager_multi.sv
// Integer + float register files with NUM_READ registered read ports, NUM_WRITE
// prioritised writeback ports and a busy scoreboard. Define REGMGR_BYPASS_EN to forward same-edge writes.
module register_manager_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_READ-1:0]              rd_float,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic [NUM_WRITE-1:0]             wr_enable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
  input  logic [NUM_WRITE-1:0]             wr_float,
  input  logic                             rsv_enable,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  input  logic                             rsv_float
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0]     int_q, int_d, flt_q, flt_d;
  logic [NREG-1:0]                     int_busy_q, int_busy_d, flt_busy_q, flt_busy_d;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_READ-1:0]                 rd_busy_q, rd_busy_d;

  always_comb begin
    int_d      = int_q;
    flt_d      = flt_q;
    int_busy_d = int_busy_q;
    flt_busy_d = flt_busy_q;
    rd_data_d  = rd_data_q;
    rd_busy_d  = rd_busy_q;
    // Ascending port order: the highest-numbered colliding port lands last and wins.
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (wr_enable[p]) begin
        if (wr_float[p]) begin
          flt_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]      = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          flt_busy_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end else if (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
          int_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]      = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          int_busy_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
      end
    end
    // A reserve after the write clear keeps the newer producer pending.
    if (rsv_enable) begin
      if (rsv_float)            flt_busy_d[rsv_addr] = 1'b1;
      else if (rsv_addr != '0)  int_busy_d[rsv_addr] = 1'b1;
    end
    int_d[0]      = '0;
    int_busy_d[0] = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
`ifdef REGMGR_BYPASS_EN
      rd_data_d[i] = rd_float[i] ? flt_d[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                                 : int_d[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy_d[i] = rd_float[i] ? flt_busy_d[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                                 : int_busy_d[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`else
      rd_data_d[i] = rd_float[i] ? flt_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                                 : int_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy_d[i] = rd_float[i] ? flt_busy_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                                 : int_busy_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int_q      <= '0;
      flt_q      <= '0;
      int_busy_q <= '0;
      flt_busy_q <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
    end else begin
      int_q      <= int_d;
      flt_q      <= flt_d;
      int_busy_q <= int_busy_d;
      flt_busy_q <= flt_busy_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
endmodule

// File: tb/tb_register_manager_multi.sv
// Directed test-plan sequence plus random traffic, checked against an array-based model.
module tb_register_manager_multi;
  localparam int DW = 32, AW = 5, NR = 2, NW = 4, NREG = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_float;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_enable;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     wr_float;
  logic              rsv_enable;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_float;

  int checks = 0, errors = 0;

  logic [DW-1:0] mi [NREG];
  logic [DW-1:0] mf [NREG];
  bit            bi [NREG];
  bit            bf [NREG];
  logic [DW-1:0] er [NR];
  bit            eb [NR];

  register_manager_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_float(rd_float), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_float(wr_float), .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .rsv_float(rsv_float)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    wr_enable = '0; wr_addr = '0; wr_data = '0; wr_float = '0;
    rsv_enable = 1'b0; rsv_addr = '0; rsv_float = 1'b0;
  endtask

  task automatic set_wr(input int p, input bit f, input int a, input logic [DW-1:0] d);
    wr_enable[p] = 1'b1;
    wr_float[p]  = f;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input bit f, input int a);
    rd_float[i] = f;
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  // Model: register contents as plain arrays; a cycle applies writes port by port
  // (later port overrides), then the reserve, then samples the reads.
  task automatic tick();
    logic [DW-1:0] ni [NREG];
    logic [DW-1:0] nf [NREG];
    bit nbi [NREG];
    bit nbf [NREG];
    int a;
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin mi[r] = '0; mf[r] = '0; bi[r] = 0; bf[r] = 0; end
      for (int i = 0; i < NR; i++) begin er[i] = '0; eb[i] = 0; end
    end else begin
      ni = mi; nf = mf; nbi = bi; nbf = bf;
      for (int p = 0; p < NW; p++) if (wr_enable[p]) begin
        a = int'(wr_addr[p*AW +: AW]);
        if (wr_float[p]) begin nf[a] = wr_data[p*DW +: DW]; nbf[a] = 0; end
        else if (a != 0) begin ni[a] = wr_data[p*DW +: DW]; nbi[a] = 0; end
      end
      if (rsv_enable) begin
        if (rsv_float) nbf[rsv_addr] = 1;
        else if (rsv_addr != 0) nbi[rsv_addr] = 1;
      end
      for (int i = 0; i < NR; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
`ifdef REGMGR_BYPASS_EN
        er[i] = rd_float[i] ? nf[a] : ni[a];
        eb[i] = rd_float[i] ? nbf[a] : nbi[a];
`else
        er[i] = rd_float[i] ? mf[a] : mi[a];
        eb[i] = rd_float[i] ? bf[a] : bi[a];
`endif
      end
      mi = ni; mf = nf; bi = nbi; bf = nbf;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      chk("model_rd_data", 64'(rd_data[i*DW +: DW]), 64'(er[i]));
      chk("model_rd_busy", 64'(rd_busy[i]), 64'(eb[i]));
    end
  endtask

  function automatic logic [DW-1:0] rd0();
    return rd_data[DW-1:0];
  endfunction
  function automatic logic [DW-1:0] rd1();
    return rd_data[2*DW-1:DW];
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0; rd_float = '0; idle();
    tick(); tick();
    chk("reset_rd_data", 64'(rd_data), 64'(0));
    chk("reset_rd_busy", 64'(rd_busy), 64'(0));
    reset = 1'b0;

    // write then read, held
    set_rd(0, 0, 4); set_rd(1, 1, 4);
    set_wr(1, 0, 4, 8); tick(); idle(); tick();
    for (int k = 0; k < 4; k++) begin chk("hold_r4_8", 64'(rd0()), 64'd8); tick(); end
    set_wr(0, 0, 4, 16); tick(); idle(); tick(); chk("misc_r4_16", 64'(rd0()), 64'd16);
    set_wr(2, 0, 4, 42); tick(); idle(); tick(); chk("mem_r4_42", 64'(rd0()), 64'd42);

    // file separation
    set_wr(3, 1, 4, 92); tick(); idle(); tick();
    chk("flt_r4_92", 64'(rd1()), 64'd92);
    chk("int_r4_still_42", 64'(rd0()), 64'd42);
    set_wr(1, 0, 4, 92); set_wr(2, 1, 8, 3); set_wr(3, 1, 4, 30); tick(); idle(); tick();
    chk("int_r4_92", 64'(rd0()), 64'd92);
    chk("flt_r4_30", 64'(rd1()), 64'd30);
    set_rd(1, 1, 8); tick(); chk("flt_r8_3", 64'(rd1()), 64'd3);

    // collision priority and int r0
    set_rd(0, 0, 7);
    set_wr(1, 0, 7, 5); set_wr(3, 0, 7, 9); tick(); idle(); tick();
    chk("collide_r7_9", 64'(rd0()), 64'd9);
    set_rd(0, 0, 0);
    set_wr(2, 0, 0, 32'h1234); tick(); idle(); tick();
    chk("int_r0_zero", 64'(rd0()), 64'd0);

    // forwarding behaviour
    set_rd(0, 0, 5); tick();
    set_wr(1, 0, 5, 29); tick(); idle();
`ifdef REGMGR_BYPASS_EN
    chk("bypass_first_edge", 64'(rd0()), 64'd29);
`else
    chk("nobypass_first_edge", 64'(rd0() != 29), 64'd1);
`endif
    tick(); chk("r5_second_edge", 64'(rd0()), 64'd29);

    // scoreboard
    set_rd(0, 0, 6);
    rsv_enable = 1'b1; rsv_addr = 5'd6; tick(); idle(); tick();
    chk("rsv_busy", 64'(rd_busy[0]), 64'd1);
    rsv_enable = 1'b1; rsv_addr = 5'd6; set_wr(2, 0, 6, 7); tick(); idle(); tick();
    chk("rsv_wr_still_busy", 64'(rd_busy[0]), 64'd1);
    set_wr(0, 0, 6, 11); tick(); idle(); tick();
    chk("wr_clears_busy", 64'(rd_busy[0]), 64'd0);
    chk("r6_11", 64'(rd0()), 64'd11);
    rsv_enable = 1'b1; rsv_addr = 5'd0; set_rd(0, 0, 0); tick(); idle(); tick();
    chk("r0_never_busy", 64'(rd_busy[0]), 64'd0);

    // reset mid-operation
    set_rd(0, 0, 4); set_rd(1, 1, 4);
    reset = 1'b1; set_wr(1, 0, 4, 77); tick(); idle(); reset = 1'b0;
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    tick(); tick();
    chk("rst_r4_int", 64'(rd0()), 64'd0);
    chk("rst_r4_flt", 64'(rd1()), 64'd0);

    // random traffic on a narrow address range to force collisions
    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      rsv_enable = 1'($urandom_range(0, 2) == 0);
      rsv_addr   = AW'($urandom_range(0, 7));
      rsv_float  = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) set_rd(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
